// File: rtl/fpu_vector_checker.sv
// fpu_vector_checker
//   Holds up to DEPTH test vectors (opcode, two operands, expected result).
//   Start replays them into the fpu at one per clock. Each fpu result is
//   checked against its expected word LATENCY cycles after issue. Pass/fail
//   counts and the index of the first failing vector are reported.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   load_*              vector write handshake into the store (IDLE only)
//   start, clear        run trigger / abort-and-empty
//   fpu_op/opa/opb      operands driven to the fpu, zero outside ISSUE
//   fpu_out             fpu result, sampled when a valid tag exits
//   busy, done          run status
//   pass_cnt, fail_cnt  saturating result counters
//   fail_flag           at least one mismatch in this run
//   first_fail_idx      index of the first mismatching vector
module fpu_vector_checker #(
  parameter int FPU_TYPE  = 0,
  parameter int BIT_SIZE  = 16*2**(2-FPU_TYPE)-1,
  parameter int EXP_SIZE  = 11-(3*FPU_TYPE)-1,
  parameter int MANT_SIZE = BIT_SIZE-EXP_SIZE-2,
  parameter int DEPTH     = 16,
  parameter int LATENCY   = 4,
  parameter int NAN_LOOSE = 1,
  localparam int CNT_W    = $clog2(DEPTH+1),
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [2:0]        load_op,
  input  logic [BIT_SIZE:0] load_opa,
  input  logic [BIT_SIZE:0] load_opb,
  input  logic [BIT_SIZE:0] load_exp,
  input  logic              start,
  input  logic              clear,
  output logic [2:0]        fpu_op,
  output logic [BIT_SIZE:0] fpu_opa,
  output logic [BIT_SIZE:0] fpu_opb,
  input  logic [BIT_SIZE:0] fpu_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              fail_flag,
  output logic [IDX_W-1:0]  first_fail_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Marks the oldest pipeline stage; a tag there is being compared this cycle.
  localparam logic [LATENCY-1:0] EXIT_MASK = LATENCY'(1) << (LATENCY-1);

  // NaN: exponent all ones and a nonzero mantissa.
  function automatic logic is_nan(input logic [BIT_SIZE:0] w);
    return (&w[MANT_SIZE+1 +: EXP_SIZE+1]) && (|w[MANT_SIZE:0]);
  endfunction

  // Bit-exact match, optionally treating any two NaNs as equal.
  function automatic logic words_match(input logic [BIT_SIZE:0] a, input logic [BIT_SIZE:0] b);
    if (a == b) begin
      return 1'b1;
    end else if (NAN_LOOSE != 0) begin
      return is_nan(a) && is_nan(b);
    end else begin
      return 1'b0;
    end
  endfunction

  // Vector store
  logic [2:0]        mem_op_r  [DEPTH];
  logic [BIT_SIZE:0] mem_opa_r [DEPTH];
  logic [BIT_SIZE:0] mem_opb_r [DEPTH];
  logic [BIT_SIZE:0] mem_exp_r [DEPTH];

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  count_r, count_next_s;
  logic [IDX_W-1:0]  issue_idx_r, issue_next_s;
  logic              load_ready_r, busy_r, done_r;
  logic              load_ready_s, busy_s, done_s;
  logic [2:0]        fpu_op_r, fpu_op_s;
  logic [BIT_SIZE:0] fpu_opa_r, fpu_opa_s;
  logic [BIT_SIZE:0] fpu_opb_r, fpu_opb_s;
  logic              load_fire_s, start_ok_s, last_issue_s, pending_s;

  logic [LATENCY-1:0] tag_valid_r;
  logic [IDX_W-1:0]   tag_idx_r [LATENCY];
  logic               exit_valid_s, match_s;
  logic [IDX_W-1:0]   exit_idx_s;

  logic [CNT_W-1:0]  pass_cnt_r, fail_cnt_r;
  logic              fail_flag_r;
  logic [IDX_W-1:0]  first_fail_idx_r;

  // Handshake, entry count and run-control qualifiers.
  always_comb begin
    load_fire_s = (state_r == ST_IDLE) && load_valid && load_ready_r && !clear;
    if (clear) begin
      count_next_s = {CNT_W{1'b0}};
    end else if (load_fire_s) begin
      count_next_s = count_r + CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
    // A load in the same cycle as start counts toward the run.
    start_ok_s   = start && !clear &&
                   (((state_r == ST_IDLE) && ((count_r != {CNT_W{1'b0}}) || load_fire_s)) ||
                    (state_r == ST_DONE));
    last_issue_s = (CNT_W'(issue_idx_r) + CNT_W'(1)) == count_r;
    // Ignore the exiting stage: once only it remains, DONE lines up with the last compare.
    pending_s    = |(tag_valid_r & ~EXIT_MASK);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_s = ST_ISSUE;
        else            state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (clear)             state_s = ST_IDLE;
        else if (last_issue_s) state_s = ST_DRAIN;
        else                   state_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (clear)           state_s = ST_IDLE;
        else if (!pending_s) state_s = ST_DONE;
        else                 state_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (clear)           state_s = ST_IDLE;
        else if (start_ok_s) state_s = ST_ISSUE;
        else                 state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered status and fpu operand outputs.
  always_comb begin
    load_ready_s = (state_s == ST_IDLE) && (count_next_s < CNT_W'(DEPTH));
    busy_s       = (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
    done_s       = (state_s == ST_DONE);
    issue_next_s = {IDX_W{1'b0}};
    fpu_op_s     = 3'd0;
    fpu_opa_s    = {(BIT_SIZE+1){1'b0}};
    fpu_opb_s    = {(BIT_SIZE+1){1'b0}};
    if (state_s == ST_ISSUE) begin
      if (state_r == ST_ISSUE) begin
        issue_next_s = issue_idx_r + IDX_W'(1);
      end else begin
        issue_next_s = {IDX_W{1'b0}};
      end
      // Entry being written this very edge is not in the store yet.
      if (load_fire_s && (count_r == CNT_W'(issue_next_s))) begin
        fpu_op_s  = load_op;
        fpu_opa_s = load_opa;
        fpu_opb_s = load_opb;
      end else begin
        fpu_op_s  = mem_op_r[issue_next_s];
        fpu_opa_s = mem_opa_r[issue_next_s];
        fpu_opb_s = mem_opb_r[issue_next_s];
      end
    end else begin
      issue_next_s = {IDX_W{1'b0}};
    end
  end

  // State, count and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      count_r      <= {CNT_W{1'b0}};
      issue_idx_r  <= {IDX_W{1'b0}};
      load_ready_r <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fpu_op_r     <= 3'd0;
      fpu_opa_r    <= {(BIT_SIZE+1){1'b0}};
      fpu_opb_r    <= {(BIT_SIZE+1){1'b0}};
    end else begin
      state_r      <= state_s;
      count_r      <= count_next_s;
      issue_idx_r  <= issue_next_s;
      load_ready_r <= load_ready_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      fpu_op_r     <= fpu_op_s;
      fpu_opa_r    <= fpu_opa_s;
      fpu_opb_r    <= fpu_opb_s;
    end
  end

  // Vector store write port.
  always_ff @(posedge clk) begin
    if (load_fire_s && rst_n) begin
      mem_op_r[IDX_W'(count_r)]  <= load_op;
      mem_opa_r[IDX_W'(count_r)] <= load_opa;
      mem_opb_r[IDX_W'(count_r)] <= load_opb;
      mem_exp_r[IDX_W'(count_r)] <= load_exp;
    end
  end

  // Tag pipeline: stage 0 captures the vector presented during the cycle just ended.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      tag_valid_r <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        tag_idx_r[i] <= {IDX_W{1'b0}};
      end
    end else begin
      tag_valid_r[0] <= (state_r == ST_ISSUE);
      tag_idx_r[0]   <= issue_idx_r;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_idx_r[i]   <= tag_idx_r[i-1];
      end
    end
  end

  // Result compare for the exiting tag.
  always_comb begin
    exit_valid_s = tag_valid_r[LATENCY-1];
    exit_idx_s   = tag_idx_r[LATENCY-1];
    match_s      = words_match(fpu_out, mem_exp_r[exit_idx_s]);
  end

  // Result counters and first-failure capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_cnt_r       <= {CNT_W{1'b0}};
      fail_cnt_r       <= {CNT_W{1'b0}};
      fail_flag_r      <= 1'b0;
      first_fail_idx_r <= {IDX_W{1'b0}};
    end else if (clear || start_ok_s) begin
      pass_cnt_r       <= {CNT_W{1'b0}};
      fail_cnt_r       <= {CNT_W{1'b0}};
      fail_flag_r      <= 1'b0;
      first_fail_idx_r <= {IDX_W{1'b0}};
    end else if (exit_valid_s) begin
      if (match_s) begin
        if (pass_cnt_r < CNT_W'(DEPTH)) pass_cnt_r <= pass_cnt_r + CNT_W'(1);
      end else begin
        if (fail_cnt_r < CNT_W'(DEPTH)) fail_cnt_r <= fail_cnt_r + CNT_W'(1);
        if (!fail_flag_r) begin
          fail_flag_r      <= 1'b1;
          first_fail_idx_r <= exit_idx_s;
        end
      end
    end
  end

  assign load_ready     = load_ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign fpu_op         = fpu_op_r;
  assign fpu_opa        = fpu_opa_r;
  assign fpu_opb        = fpu_opb_r;
  assign pass_cnt       = pass_cnt_r;
  assign fail_cnt       = fail_cnt_r;
  assign fail_flag      = fail_flag_r;
  assign first_fail_idx = first_fail_idx_r;

endmodule

// File: tb/tb_fpu_vector_checker.sv
// Directed bench for fpu_vector_checker. Three instances: 64-bit with loose
// NaN compare, 64-bit bit-exact (sharing all inputs with the first), and a
// 32-bit one. A small behavioural fpu (op 0 = add via reals, op 1 = pass a)
// with LATENCY stages produces fpu_out.
module tb_fpu_vector_checker;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, load_valid, start, clear;
  logic [2:0]  load_op;
  logic [63:0] load_opa, load_opb, load_exp, fpu_out;
  logic        load_ready, busy, done, fail_flag;
  logic [2:0]  fpu_op;
  logic [63:0] fpu_opa, fpu_opb;
  logic [4:0]  pass_cnt, fail_cnt;
  logic [3:0]  first_fail_idx;

  logic        s_load_ready, s_busy, s_done, s_fail_flag;
  logic [2:0]  s_fpu_op;
  logic [63:0] s_fpu_opa, s_fpu_opb;
  logic [4:0]  s_pass_cnt, s_fail_cnt;
  logic [3:0]  s_first_fail_idx;

  logic        v_load_valid, v_start, v_load_ready, v_busy, v_done, v_fail_flag;
  logic [2:0]  v_load_op, v_fpu_op;
  logic [31:0] v_load_opa, v_load_opb, v_load_exp, v_fpu_opa, v_fpu_opb, v_fpu_out;
  logic [4:0]  v_pass_cnt, v_fail_cnt;
  logic [3:0]  v_first_fail_idx;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_vector_checker #(.FPU_TYPE(0), .LATENCY(LAT), .NAN_LOOSE(1)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_op(load_op), .load_opa(load_opa), .load_opb(load_opb), .load_exp(load_exp),
    .start(start), .clear(clear), .fpu_op(fpu_op), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
    .fpu_out(fpu_out), .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_flag(fail_flag), .first_fail_idx(first_fail_idx));

  fpu_vector_checker #(.FPU_TYPE(0), .LATENCY(LAT), .NAN_LOOSE(0)) dut_strict (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(s_load_ready),
    .load_op(load_op), .load_opa(load_opa), .load_opb(load_opb), .load_exp(load_exp),
    .start(start), .clear(clear), .fpu_op(s_fpu_op), .fpu_opa(s_fpu_opa), .fpu_opb(s_fpu_opb),
    .fpu_out(fpu_out), .busy(s_busy), .done(s_done), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
    .fail_flag(s_fail_flag), .first_fail_idx(s_first_fail_idx));

  fpu_vector_checker #(.FPU_TYPE(1), .LATENCY(LAT), .NAN_LOOSE(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .load_valid(v_load_valid), .load_ready(v_load_ready),
    .load_op(v_load_op), .load_opa(v_load_opa), .load_opb(v_load_opb), .load_exp(v_load_exp),
    .start(v_start), .clear(clear), .fpu_op(v_fpu_op), .fpu_opa(v_fpu_opa), .fpu_opb(v_fpu_opb),
    .fpu_out(v_fpu_out), .busy(v_busy), .done(v_done), .pass_cnt(v_pass_cnt), .fail_cnt(v_fail_cnt),
    .fail_flag(v_fail_flag), .first_fail_idx(v_first_fail_idx));

  // Single <-> double conversion for normal numbers and zero.
  function automatic logic [63:0] s2d(input logic [31:0] x);
    logic [10:0] e;
    e = {3'b000, x[30:23]} + 11'd896;
    if (x[30:23] == 8'd0) return {x[31], 63'd0};
    else                  return {x[31], e, x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [10:0] e;
    e = d[62:52] - 11'd896;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    else                   return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [63:0] fpu64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    real r;
    case (op)
      3'd0: begin r = $bitstoreal(a) + $bitstoreal(b); return $realtobits(r); end
      3'd1: return a;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] fpu32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    real r;
    case (op)
      3'd0: begin r = $bitstoreal(s2d(a)) + $bitstoreal(s2d(b)); return d2s($realtobits(r)); end
      3'd1: return a;
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural fpu pipelines.
  logic [63:0] pipe64 [LAT];
  logic [31:0] pipe32 [LAT];
  always @(posedge clk) begin
    pipe64[0] <= fpu64(fpu_op, fpu_opa, fpu_opb);
    pipe32[0] <= fpu32(v_fpu_op, v_fpu_opa, v_fpu_opb);
    for (int i = 1; i < LAT; i++) begin
      pipe64[i] <= pipe64[i-1];
      pipe32[i] <= pipe32[i-1];
    end
  end
  assign fpu_out   = pipe64[LAT-1];
  assign v_fpu_out = pipe32[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    load_op = op; load_opa = a; load_opb = b; load_exp = e;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_done(input int sel, input string tag, input int budget);
    int n;
    n = 0;
    while (((sel == 0) ? done : v_done) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'((sel == 0) ? done : v_done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; start = 1'b0; clear = 1'b0;
    load_op = 3'd0; load_opa = 64'd0; load_opb = 64'd0; load_exp = 64'd0;
    v_load_valid = 1'b0; v_start = 1'b0; v_load_op = 3'd0;
    v_load_opa = 32'd0; v_load_opb = 32'd0; v_load_exp = 32'd0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_load_ready", 64'(load_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass_cnt), 64'd0);
    chk("rst_fail", 64'(fail_cnt), 64'd0);
    chk("rst_flag", 64'(fail_flag), 64'd0);
    chk("rst_ffi", 64'(first_fail_idx), 64'd0);
    chk("rst_fpu_opa", fpu_opa, 64'd0);
    chk("rst_v_load_ready", 64'(v_load_ready), 64'd1);

    // start with an empty store is ignored
    pulse_start();
    chk("empty_start_busy", 64'(busy), 64'd0);
    chk("empty_start_done", 64'(done), 64'd0);

    // Scenario 1: single passing vector, done at t0+LATENCY+1
    load64(3'd0, 64'h191536e3e743a545, 64'hf5ceb434501dc11c, 64'hf5ceb434501dc11c);
    pulse_start();
    chk("s1_fpu_opa_issue", fpu_opa, 64'h191536e3e743a545);
    repeat (LAT) tick();
    chk("s1_done_not_yet", 64'(done), 64'd0);
    chk("s1_busy_drain", 64'(busy), 64'd1);
    tick();
    chk("s1_done", 64'(done), 64'd1);
    chk("s1_busy", 64'(busy), 64'd0);
    chk("s1_pass", 64'(pass_cnt), 64'd1);
    chk("s1_fail", 64'(fail_cnt), 64'd0);
    chk("s1_flag", 64'(fail_flag), 64'd0);
    chk("s1_load_ready", 64'(load_ready), 64'd0);

    // Scenario 2: expected off by one ulp
    do_clear();
    chk("s2_clear_ready", 64'(load_ready), 64'd1);
    load64(3'd0, 64'h191536e3e743a545, 64'hf5ceb434501dc11c, 64'hf5ceb434501dc11d);
    pulse_start();
    wait_done(0, "s2_wait_done", 20);
    chk("s2_pass", 64'(pass_cnt), 64'd0);
    chk("s2_fail", 64'(fail_cnt), 64'd1);
    chk("s2_flag", 64'(fail_flag), 64'd1);
    chk("s2_ffi", 64'(first_fail_idx), 64'd0);

    // Scenario 3: full store, mismatches at 5 and 9
    do_clear();
    for (int i = 0; i < 16; i++) begin
      logic [63:0] w;
      w = {32'hA5A50000, 32'(i)};
      load64(3'd1, w, 64'd0, (i == 5 || i == 9) ? (w ^ 64'd1) : w);
      if (i == 14) chk("s3_ready_before_full", 64'(load_ready), 64'd1);
    end
    chk("s3_ready_full", 64'(load_ready), 64'd0);
    load64(3'd1, 64'h1234, 64'd0, 64'h9999);
    chk("s3_ready_after_17th", 64'(load_ready), 64'd0);
    pulse_start();
    wait_done(0, "s3_wait_done", 40);
    chk("s3_pass", 64'(pass_cnt), 64'd14);
    chk("s3_fail", 64'(fail_cnt), 64'd2);
    chk("s3_ffi", 64'(first_fail_idx), 64'd5);
    chk("s3_flag", 64'(fail_flag), 64'd1);
    chk("s3_strict_pass", 64'(s_pass_cnt), 64'd14);

    // Scenario 4: NaN looseness, signed zero; second load coincides with start
    do_clear();
    load64(3'd1, 64'h7ff0000000000001, 64'd0, 64'h7ff8000000000000);
    load_op = 3'd1; load_opa = 64'd0; load_opb = 64'd0; load_exp = 64'h8000000000000000;
    load_valid = 1'b1; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0;
    wait_done(0, "s4_wait_done", 20);
    chk("s4_loose_pass", 64'(pass_cnt), 64'd1);
    chk("s4_loose_fail", 64'(fail_cnt), 64'd1);
    chk("s4_loose_ffi", 64'(first_fail_idx), 64'd1);
    chk("s4_strict_pass", 64'(s_pass_cnt), 64'd0);
    chk("s4_strict_fail", 64'(s_fail_cnt), 64'd2);
    chk("s4_strict_ffi", 64'(s_first_fail_idx), 64'd0);
    chk("s4_strict_done", 64'(s_done), 64'd1);

    // Scenario 5a: clear during ISSUE
    do_clear();
    for (int i = 0; i < 4; i++) load64(3'd1, 64'h1000 + 64'(i), 64'd0, 64'h1000 + 64'(i));
    pulse_start();
    chk("s5_opa_k0", fpu_opa, 64'h1000);
    tick();
    chk("s5_opa_k1", fpu_opa, 64'h1001);
    chk("s5_strict_opa_k1", s_fpu_opa, 64'h1001);
    chk("s5_busy_issue", 64'(busy), 64'd1);
    chk("s5_ready_issue", 64'(load_ready), 64'd0);
    do_clear();
    chk("s5_clr_busy", 64'(busy), 64'd0);
    chk("s5_clr_done", 64'(done), 64'd0);
    chk("s5_clr_ready", 64'(load_ready), 64'd1);
    chk("s5_clr_opa", fpu_opa, 64'd0);
    repeat (LAT + 4) tick();
    chk("s5_clr_pass", 64'(pass_cnt), 64'd0);
    chk("s5_clr_fail", 64'(fail_cnt), 64'd0);
    chk("s5_clr_done_later", 64'(done), 64'd0);

    // Scenario 5b: reset during DRAIN
    load64(3'd1, 64'h2000, 64'd0, 64'h2000);
    load64(3'd1, 64'h2001, 64'd0, 64'h2001);
    pulse_start();
    tick(); tick();
    chk("s5_drain_busy", 64'(busy), 64'd1);
    chk("s5_drain_opa", fpu_opa, 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s5_rst_busy", 64'(busy), 64'd0);
    chk("s5_rst_ready", 64'(load_ready), 64'd1);
    chk("s5_rst_pass", 64'(pass_cnt), 64'd0);
    repeat (LAT + 2) tick();
    chk("s5_rst_pass_later", 64'(pass_cnt), 64'd0);
    chk("s5_rst_done_later", 64'(done), 64'd0);

    // Scenario 6: 32-bit, 1.0 + 1.0 = 2.0, then rerun from DONE
    v_load_op = 3'd0; v_load_opa = 32'h3f800000; v_load_opb = 32'h3f800000; v_load_exp = 32'h40000000;
    v_load_valid = 1'b1;
    tick();
    v_load_valid = 1'b0;
    v_start = 1'b1;
    tick();
    v_start = 1'b0;
    wait_done(1, "s6_wait_done", 20);
    chk("s6_pass", 64'(v_pass_cnt), 64'd1);
    chk("s6_fail", 64'(v_fail_cnt), 64'd0);
    v_start = 1'b1;
    tick();
    v_start = 1'b0;
    chk("s6_rerun_zeroed", 64'(v_pass_cnt), 64'd0);
    chk("s6_rerun_busy", 64'(v_busy), 64'd1);
    chk("s6_rerun_done_low", 64'(v_done), 64'd0);
    wait_done(1, "s6_rerun_wait_done", 20);
    chk("s6_rerun_pass", 64'(v_pass_cnt), 64'd1);
    chk("s6_rerun_flag", 64'(v_fail_flag), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_vector_checker.md
Name: fpu_vector_checker

Overview:
Parametrised, synthesisable vector sequencer and result checker for the fpu core.
- Stores up to DEPTH vectors, each an opcode, two operands and an expected result.
- On start, issues one vector per clock to the fpu and compares each fpu result against its expected value after a fixed LATENCY.
- Reports pass/fail counts and the index of the first failing vector.
- Runs at any precision selected by FPU_TYPE, for on-chip regression of the fpu.

Parameters:
FPU_TYPE, 0, precision select: 0 = 64-bit, 1 = 32-bit, 2 = 16-bit.
BIT_SIZE, 16*2**(2-FPU_TYPE)-1, MSB index of an operand.
EXP_SIZE, 11-(3*FPU_TYPE)-1, MSB index of the exponent field.
MANT_SIZE, BIT_SIZE-EXP_SIZE-2, MSB index of the mantissa field.
DEPTH, 16, vector store entries; must be at least 1.
LATENCY, 4, fpu cycles from operand presentation to a valid out; must be at least 1.
NAN_LOOSE, 1, when 1 any NaN result matches any NaN expected value; when 0 comparison is bit-exact.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
load_valid  in  1  vector write request
load_ready  out  1  store accepts a vector
load_op  in  3  fpu opcode
load_opa  in  BIT_SIZE+1  operand a
load_opb  in  BIT_SIZE+1  operand b
load_exp  in  BIT_SIZE+1  expected result
start  in  1  begin run, one-cycle pulse
clear  in  1  abort and empty the store
fpu_op  out  3  opcode presented to the fpu
fpu_opa  out  BIT_SIZE+1  operand a presented to the fpu
fpu_opb  out  BIT_SIZE+1  operand b presented to the fpu
fpu_out  in  BIT_SIZE+1  fpu result
busy  out  1  run in progress
done  out  1  run complete
pass_cnt  out  $clog2(DEPTH+1)  number of matching results
fail_cnt  out  $clog2(DEPTH+1)  number of mismatching results
fail_flag  out  1  at least one mismatch this run
first_fail_idx  out  $clog2(DEPTH) (at least 1)  index of the first mismatch

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - state IDLE; entry count 0; tag pipeline empty.
  - All outputs 0 except load_ready=1.
- Reset mid-run aborts the run immediately.
- States and transitions:
  - IDLE: load_ready = (count<DEPTH). A load_valid && load_ready handshake writes entry[count] and increments count. start with count>0 goes to ISSUE; start with count==0 is ignored.
  - ISSUE: busy=1 and load_ready=0. Vector k drives fpu_op/fpu_opa/fpu_opb from registers during the k-th cycle of ISSUE, k = 0..count-1. After the last vector is issued, go to DRAIN.
  - DRAIN: busy=1. Wait until the tag pipeline is empty, then go to DONE.
  - DONE: done=1, busy=0, load_ready=0. start re-runs the same vectors (to ISSUE). clear goes to IDLE.
- fpu_op/opa/opb are 0 in every state except ISSUE.
- Tag pipeline:
  - LATENCY-stage shift register of {valid, index}, loaded on each issue cycle.
  - When a valid tag exits, fpu_out is compared with entry[index].exp in that same cycle.
  - Counters and flags update at the following edge.
- Compare rule: pass if the two words are bit-equal.
  - With NAN_LOOSE=1, also pass if both are NaN: exponent bits [BIT_SIZE-1:MANT_SIZE+1] all 1s and mantissa [MANT_SIZE:0] nonzero.
  - Signed zeros are compared bit-exact; +0 does not match -0.
- Timing: start sampled at edge t0. The result of vector N-1 is compared during cycle t0+N-1+LATENCY. done rises at the next edge.
- A start accepted in IDLE or DONE clears pass_cnt, fail_cnt, fail_flag and first_fail_idx.
- First mismatch: first_fail_idx captures its index and fail_flag sets. Later mismatches do not change first_fail_idx.
- Simultaneous load handshake and start in IDLE: the load is accepted and the new entry is included in the run.
- clear in any state:
  - Next state IDLE; count 0; tag pipeline flushed.
  - Counters and flags zeroed.
  - clear takes priority over start and load.
- Counters saturate at DEPTH and never wrap.

Test Plan:
1. FPU_TYPE=0. Load op=0, opa=64'h191536e3e743a545, opb=64'hf5ceb434501dc11c, exp=64'hf5ceb434501dc11c; pulse start -> done rises at t0+LATENCY+1, pass_cnt=1, fail_cnt=0, fail_flag=0.
2. Same as scenario 1 but exp=64'hf5ceb434501dc11d -> fail_cnt=1, fail_flag=1, first_fail_idx=0.
3. Load 16 vectors -> load_ready=0 after the 16th handshake; a 17th load_valid is not accepted. Run with mismatches at indices 5 and 9 -> pass_cnt=14, fail_cnt=2, first_fail_idx=5.
4. fpu_out=64'h7ff0000000000001, exp=64'h7ff8000000000000 -> pass with NAN_LOOSE=1; fail with NAN_LOOSE=0. exp=64'h8000000000000000 with out=0 -> fail.
5. clear two cycles into ISSUE -> next cycle IDLE, busy=0, counters 0, load_ready=1, no further compares. rst_n=0 mid-DRAIN gives the same result with load_ready=1.
6. FPU_TYPE=1. 32-bit vector opa=32'h3f800000, opb=32'h3f800000, op=0, exp=32'h40000000 -> pass_cnt=1. Then start in DONE -> counters re-zeroed and pass_cnt=1 again.
